spi_program_sender: RTL and testbench
=====================================

// Module: spi_program_sender
// PURPOSE
//  SPI mode-0 master that streams a program image, byte by byte, over SCK/CSn/MOSI.
//  It is the initiating end of the SPI program-load link consumed by the core's program loader.
//  Used in test benches and on a host/bridge FPGA to push images into the target's instruction memory.
//  Bytes arrive on a valid/ready stream. Bytes returned on MISO are captured and presented on rx_data.
// PARAMETERS
//  CLK_DIV         4   clk cycles per SCK half-period (>=1); one byte = 16*CLK_DIV clk cycles
//  CS_SETUP_CYCLES 2   clk cycles from CSn falling to first byte load (>=1)
//  CS_HOLD_CYCLES  2   clk cycles from last SCK falling edge to CSn rising (>=1)
//  LEN_WIDTH       32  width of byte_count
// PORTS
//  clk         in   1          system clock; all logic on posedge
//  rst         in   1          synchronous reset, active-high
//  start       in   1          begin a transfer; sampled only in IDLE
//  byte_count  in   LEN_WIDTH  bytes in this transfer; latched with start
//  busy        out  1          high from cycle after accepted start until done cycle inclusive
//  done        out  1          one-cycle pulse when the transfer completes
//  tx_data     in   8          next byte to send
//  tx_valid    in   1          tx_data valid
//  tx_ready    out  1          sender accepts tx_data this cycle
//  rx_data     out  8          last byte shifted in from MISO
//  rx_valid    out  1          one-cycle pulse; rx_data updated
//  SCK         out  1          SPI clock; idles low (CPOL=0)
//  CSn         out  1          chip select, active-low
//  MOSI        out  1          master out, MSB first
//  MISO        in   1          master in, sampled on SCK rising
// BEHAVIOUR
//  Reset:
//  - rst=1 on a posedge forces state to IDLE on that edge, including mid-transfer.
//  - Registered outputs: SCK=0, CSn=1, MOSI=0, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0.
//  - All outputs are registered. The partial byte is discarded.
//  States: IDLE -> CS_SETUP -> LOAD <-> SHIFT -> CS_HOLD -> FINISH -> IDLE.
//  IDLE:
//  - start=1 latches byte_count into remaining.
//  - remaining==0: go straight to FINISH; CSn stays high.
//  - Otherwise: CSn<=0 and go to CS_SETUP.
//  CS_SETUP: hold CSn low and SCK low for CS_SETUP_CYCLES, then go to LOAD.
//  LOAD:
//  - tx_ready=1. On tx_valid&&tx_ready: shreg<=tx_data, MOSI<=tx_data[7], go to SHIFT.
//  - Stalls with tx_valid=0 are unbounded; CSn stays low and SCK stays low.
//  SHIFT (8 bits, each bit = CLK_DIV cycles SCK low then CLK_DIV cycles SCK high):
//  - Rising edge: the cycle SCK goes 0->1 also shifts MISO into the rx shift register (LSB in).
//  - Falling edge: SCK 1->0 presents the next bit on MOSI; bits 6..0 in order.
//  - MOSI is stable for >= CLK_DIV cycles before every rising edge.
//  - After bit 0's high phase: SCK<=0, rx_data<=shifted byte, rx_valid=1 for one cycle, remaining-=1.
//  - Next state: LOAD if remaining!=0, else CS_HOLD. No extra gap between bytes beyond LOAD's tx_ready cycle.
//  CS_HOLD: SCK low, CSn low for CS_HOLD_CYCLES, then CSn<=1 and go to FINISH.
//  FINISH: done=1 for one cycle, busy=1 this cycle, next IDLE. busy=0 in IDLE.
//  Boundaries:
//  - start while not IDLE is ignored; byte_count changes mid-transfer are ignored.
//  - tx_ready is low outside LOAD. tx_valid outside LOAD is not consumed.
//  - remaining never underflows; at most byte_count bytes are consumed.
//  - start and rst in the same cycle: rst wins.
//  - SCK never glitches; exactly 8 rising edges per byte and none while CSn is high.
// TESTING
//  1 Reset: hold rst 3 cycles with start=1 -> SCK=0, CSn=1, MOSI=0, busy=0, tx_ready=0, done=0.
//  2 Single byte: CLK_DIV=2, byte_count=1, tx_data=0xA5, MISO tied to MOSI ->
//    slave model receives 0xA5; rx_data=0xA5 with one rx_valid; 8 SCK rises 4 clk apart; one done pulse.
//  3 Multi-byte: byte_count=4, stream DE AD BE EF with 5-cycle tx_valid gaps ->
//    slave receives DE AD BE EF; CSn low continuously; SCK low during gaps; exactly 4 tx handshakes.
//  4 Zero length: byte_count=0 -> done after 2 cycles; CSn never low; tx_ready never high.
//  5 Reset mid-byte: rst during bit 3 of byte 2 -> next cycle CSn=1, SCK=0, busy=0;
//    new start with 1 byte 0x3C completes normally.
//  6 Start while busy: second start pulse during SHIFT with byte_count=9 ->
//    ignored; transfer ends after original count; single done.

Source files
------------

// File: rtl/spi_program_sender.sv
// rtl/spi_program_sender.sv - SPI mode-0 master streaming a program image byte by byte
module spi_program_sender #(
    parameter int CLK_DIV         = 4,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int LEN_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] byte_count,
    output logic                 busy,
    output logic                 done,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 SCK,
    output logic                 CSn,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        SHIFT,
        CS_HOLD,
        FINISH
    } state_t;

    state_t               state, next_state;
    logic [LEN_WIDTH-1:0] remaining, next_remaining;
    logic [CW-1:0]        cnt, next_cnt;
    logic [2:0]           bit_idx, next_bit_idx;
    logic [7:0]           shreg, next_shreg;
    logic [7:0]           rxsh, next_rxsh;
    logic                 next_sck, next_csn, next_mosi, next_rx_valid;
    logic [7:0]           next_rx_data;

    always_comb begin
        next_state     = state;
        next_remaining = remaining;
        next_cnt       = cnt;
        next_bit_idx   = bit_idx;
        next_shreg     = shreg;
        next_rxsh      = rxsh;
        next_sck       = SCK;
        next_csn       = CSn;
        next_mosi      = MOSI;
        next_rx_data   = rx_data;
        next_rx_valid  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    next_remaining = byte_count;
                    next_cnt       = '0;
                    if (byte_count == '0) begin
                        next_state = FINISH;
                    end else begin
                        next_csn   = 1'b0;
                        next_state = CS_SETUP;
                    end
                end
            end
            CS_SETUP: begin
                if (cnt == CW'(CS_SETUP_CYCLES - 1)) begin
                    next_state = LOAD;
                end else begin
                    next_cnt = cnt + CW'(1);
                end
            end
            LOAD: begin
                if (tx_valid && tx_ready) begin
                    next_shreg   = tx_data;
                    next_mosi    = tx_data[7];
                    next_cnt     = '0;
                    next_bit_idx = 3'd7;
                    next_state   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != CW'(CLK_DIV - 1)) begin
                    next_cnt = cnt + CW'(1);
                end else begin
                    next_cnt = '0;
                    if (!SCK) begin
                        // MISO is captured on the same edge SCK is driven high
                        next_sck  = 1'b1;
                        next_rxsh = {rxsh[6:0], MISO};
                    end else begin
                        next_sck = 1'b0;
                        if (bit_idx == 3'd0) begin
                            next_rx_data   = rxsh;
                            next_rx_valid  = 1'b1;
                            next_remaining = remaining - LEN_WIDTH'(1);
                            next_state     = (remaining != LEN_WIDTH'(1)) ? LOAD : CS_HOLD;
                        end else begin
                            next_bit_idx = bit_idx - 3'd1;
                            next_shreg   = {shreg[6:0], 1'b0};
                            next_mosi    = shreg[6];
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (cnt == CW'(CS_HOLD_CYCLES - 1)) begin
                    next_csn   = 1'b1;
                    next_state = FINISH;
                end else begin
                    next_cnt = cnt + CW'(1);
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they stay registered yet aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rxsh      <= 8'h00;
            SCK       <= 1'b0;
            CSn       <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_ready  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            state     <= next_state;
            remaining <= next_remaining;
            cnt       <= next_cnt;
            bit_idx   <= next_bit_idx;
            shreg     <= next_shreg;
            rxsh      <= next_rxsh;
            SCK       <= next_sck;
            CSn       <= next_csn;
            MOSI      <= next_mosi;
            busy      <= (next_state != IDLE);
            done      <= (next_state == FINISH);
            tx_ready  <= (next_state == LOAD);
            rx_data   <= next_rx_data;
            rx_valid  <= next_rx_valid;
        end
    end

endmodule

// File: tb/tb_spi_program_sender.sv
// tb/tb_spi_program_sender.sv - self-checking bench for spi_program_sender
module tb_spi_program_sender;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] byte_count = '0;
    logic        busy, done;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sck, csn, mosi;
    logic        miso;

    assign miso = mosi;

    spi_program_sender #(
        .CLK_DIV(CLK_DIV),
        .CS_SETUP_CYCLES(2),
        .CS_HOLD_CYCLES(2),
        .LEN_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .byte_count(byte_count),
        .busy(busy), .done(done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .SCK(sck), .CSn(csn), .MOSI(mosi), .MISO(miso)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard queues and monitor counters
    logic [7:0] exp_slave[$];
    logic [7:0] exp_rx[$];
    int   cyc = 0, last_rise = 0, last_mosi_chg = 0, slave_bits = 0;
    int   rises = 0, hs = 0, dones = 0, csn_falls = 0, rdy_seen = 0, rxv = 0;
    logic [7:0] slave_sh = 8'h00;
    logic prev_sck = 1'b0, prev_mosi = 1'b0, prev_csn = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (mosi !== prev_mosi) last_mosi_chg = cyc;
        if (!csn && prev_csn) csn_falls++;
        if (csn) slave_bits = 0;
        if (sck && !prev_sck) begin
            rises++;
            chk("sck_rise_with_csn_low", csn, 0);
            chk("mosi_setup", (cyc - last_mosi_chg) >= CLK_DIV, 1);
            if (slave_bits != 0) chk("sck_period", cyc - last_rise, 2 * CLK_DIV);
            last_rise  = cyc;
            slave_sh   = {slave_sh[6:0], mosi};
            slave_bits++;
            if (slave_bits == 8) begin
                slave_bits = 0;
                chk("slave_byte_expected", exp_slave.size() > 0, 1);
                if (exp_slave.size() > 0) chk("slave_byte", slave_sh, exp_slave.pop_front());
            end
        end
        if (rx_valid) begin
            rxv++;
            chk("rx_expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
        end
        if (tx_valid && tx_ready) begin
            hs++;
            exp_slave.push_back(tx_data);
            exp_rx.push_back(tx_data);
        end
        if (tx_ready) begin
            rdy_seen++;
            chk("sck_low_in_load", sck, 0);
        end
        if (done) dones++;
        prev_sck  = sck;
        prev_mosi = mosi;
        prev_csn  = csn;
    end

    typedef struct {
        int              n;
        int              gap;
        logic [3:0][7:0] d;
        int              exp_hs;
        int              exp_rises;
        int              exp_csn_falls;
    } vec_t;

    function automatic vec_t mk(input int n, input int gap, input logic [31:0] bytes);
        vec_t v;
        v.n             = n;
        v.gap           = gap;
        v.d             = bytes;
        v.exp_hs        = n;
        v.exp_rises     = 8 * n;
        v.exp_csn_falls = (n > 0) ? 1 : 0;
        return v;
    endfunction

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        rises = 0; hs = 0; dones = 0; csn_falls = 0; rdy_seen = 0; rxv = 0;
        start = 1'b1;
        byte_count = n;
        @(negedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("done_two_cycles_after_start", done, (n == 0) ? 1 : 0);
    endtask

    task automatic feed(input logic [7:0] b, input int gap);
        bit ok;
        ok = 0;
        repeat (gap) @(posedge clk);
        #1 tx_data = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("tx_handshake");
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && dones == 0; i++) @(negedge clk);
        if (dones == 0) fail("done");
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        do_start(v.n);
        for (int i = 0; i < v.n; i++) feed(v.d[3 - i], v.gap);
        wait_done();
        repeat (4) @(negedge clk);
        chk({tag, "_handshakes"}, hs, v.exp_hs);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_sck_rises"}, rises, v.exp_rises);
        chk({tag, "_csn_falls"}, csn_falls, v.exp_csn_falls);
        chk({tag, "_tx_ready_seen"}, rdy_seen > 0, v.n > 0);
        chk({tag, "_rx_valids"}, rxv, v.n);
        chk({tag, "_slave_left"}, exp_slave.size(), 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_csn"}, csn, 1);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = mk(1, 0, 32'hA500_0000);
        vecs[1] = mk(4, 5, 32'hDEAD_BEEF);
        vecs[2] = mk(0, 0, 32'h0000_0000);
        vecs[3] = mk(2, 1, 32'h00FF_0000);
        vecs[4] = mk(3, 0, 32'h0180_5A00);

        // Reset held with start asserted
        rst = 1'b1;
        start = 1'b1;
        byte_count = 5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sck", sck, 0);
        chk("rst_csn", csn, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 0);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Reset during bit 3 of the second byte
        do_start(3);
        feed(8'h11, 0);
        feed(8'h22, 0);
        for (int i = 0; i < 500 && rises < 13; i++) @(negedge clk);
        if (rises < 13) fail("midbyte_rises");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_csn", csn, 1);
        chk("midrst_sck", sck, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_ready", tx_ready, 0);
        @(posedge clk);
        #1 exp_slave.delete();
        exp_rx.delete();
        run_vec(mk(1, 0, 32'h3C00_0000), "after_rst");

        // Second start while shifting is ignored
        do_start(2);
        feed(8'hC3, 0);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        byte_count = 9;
        @(posedge clk);
        #1 start = 1'b0;
        feed(8'h7E, 0);
        wait_done();
        repeat (60) @(negedge clk);
        chk("restart_handshakes", hs, 2);
        chk("restart_done_pulses", dones, 1);
        chk("restart_sck_rises", rises, 16);
        chk("restart_busy", busy, 0);
        chk("restart_slave_left", exp_slave.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
